// File: rtl/prbs_serial_tx_if.sv
// Control and serial-output signal group for prbs_serial_tx.
// The slave modport is the transmitter side and the master modport is the controller side.
interface prbs_serial_tx_if #(
  parameter int unsigned DIV_WIDTH = 4
);
  logic                 send_enable;
  logic                 continuous;
  logic [DIV_WIDTH-1:0] speedctr;
  logic                 serial_out;
  logic                 bit_strobe;
  logic                 busy;
  logic                 frame_done;

  modport slave (
    input  send_enable, continuous, speedctr,
    output serial_out, bit_strobe, busy, frame_done
  );

  modport master (
    output send_enable, continuous, speedctr,
    input  serial_out, bit_strobe, busy, frame_done
  );
endinterface

// File: rtl/prbs_serial_tx.sv
// Single-clock PRBS frame transmitter with a run-time bit-rate divider and single-shot or continuous frames.
// Defining PRBS_PREAMBLE_EN prefixes every frame with the PREAMBLE word, sent MSB first.
module prbs_serial_tx #(
  parameter int unsigned           WORD_WIDTH  = 10,
  parameter int unsigned           FRAME_WORDS = 8,
  parameter int unsigned           POLY_LENGTH = 9,
  parameter int unsigned           POLY_TAP    = 5,
  parameter bit                    INV_PATTERN = 1'b1,
  parameter logic [POLY_LENGTH-1:0] SEED       = '1,
  parameter int unsigned           DIV_WIDTH   = 4,
  parameter bit                    IDLE_LEVEL  = 1'b0,
  parameter logic [WORD_WIDTH-1:0] PREAMBLE    = 10'b1111100000
) (
  input logic            clk,
  input logic            rst,
  prbs_serial_tx_if.slave bus
);

`ifdef PRBS_PREAMBLE_EN
  localparam int unsigned PRE_BITS = WORD_WIDTH;
`else
  localparam int unsigned PRE_BITS = 0;
`endif
  localparam int unsigned FRAME_BITS = FRAME_WORDS * WORD_WIDTH + PRE_BITS;
  localparam int unsigned BCNT_W     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [BCNT_W-1:0] LAST = BCNT_W'(FRAME_BITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q;
  logic [POLY_LENGTH-1:0] lfsr_q;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   pcnt_q;
  logic [BCNT_W-1:0]      bcnt_q;
  logic                   serial_q;
  logic                   strobe_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   bit_edge;
  logic                   last_bit;
  logic                   start;
  logic                   frame_end;
  logic                   emit;
  logic                   relatch;
  logic                   restart;
  logic [POLY_LENGTH-1:0] src_lfsr;
  logic                   fb;
  logic [BCNT_W-1:0]      nidx_d;
  logic [POLY_LENGTH-1:0] lfsr_d;
  logic                   bit_d;
`ifdef PRBS_PREAMBLE_EN
  logic [WORD_WIDTH-1:0]  pre_q;
  logic [WORD_WIDTH-1:0]  src_pre;
  logic [WORD_WIDTH-1:0]  pre_d;
  localparam logic [BCNT_W-1:0] PRE_LAST = BCNT_W'(WORD_WIDTH - 1);
`endif

  // The bit that goes out on the next emitting edge is computed once here, whether it
  // opens a fresh frame, continues a frame, or opens a continuous repeat.
  always_comb begin
    bit_edge  = (state_q == SHIFT) && (pcnt_q == '0);
    last_bit  = (bcnt_q == LAST);
    start     = (state_q == IDLE) && bus.send_enable;
    frame_end = bit_edge && last_bit;
    emit      = start || (bit_edge && (!last_bit || bus.continuous));
    relatch   = start || (frame_end && bus.continuous);
    restart   = (state_q == IDLE) || last_bit;
    src_lfsr  = (state_q == IDLE) ? SEED : lfsr_q;
    nidx_d    = restart ? '0 : bcnt_q + 1'b1;
    fb        = src_lfsr[POLY_LENGTH-1] ^ src_lfsr[POLY_TAP-1];
    lfsr_d    = {src_lfsr[POLY_LENGTH-2:0], fb};
    bit_d     = fb ^ INV_PATTERN;
`ifdef PRBS_PREAMBLE_EN
    src_pre = restart ? PREAMBLE : pre_q;
    pre_d   = src_pre << 1;
    if (nidx_d <= PRE_LAST) begin
      bit_d  = src_pre[WORD_WIDTH-1];
      lfsr_d = src_lfsr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      div_q    <= '0;
      pcnt_q   <= '0;
      bcnt_q   <= '0;
      serial_q <= IDLE_LEVEL;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PRBS_PREAMBLE_EN
      pre_q    <= PREAMBLE;
`endif
    end else begin
      done_q   <= frame_end;
      strobe_q <= emit;
      if (relatch) div_q <= bus.speedctr;
      if (emit) begin
        state_q  <= SHIFT;
        serial_q <= bit_d;
        lfsr_q   <= lfsr_d;
        bcnt_q   <= nidx_d;
        pcnt_q   <= relatch ? bus.speedctr : div_q;
        busy_q   <= 1'b1;
`ifdef PRBS_PREAMBLE_EN
        pre_q    <= pre_d;
`endif
      end else if (frame_end) begin
        state_q  <= IDLE;
        serial_q <= IDLE_LEVEL;
        bcnt_q   <= '0;
        busy_q   <= 1'b0;
      end else if (state_q == SHIFT) begin
        pcnt_q <= pcnt_q - 1'b1;
      end
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.bit_strobe = strobe_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: doc/prbs_serial_tx.md
Name: prbs_serial_tx

Overview:
Parametrised single-clock PRBS frame transmitter. It merges pattern generation and serialisation into one block and adds a run-time bit-rate divider (f_bit = f_clk/(speedctr+1)). It also adds single-shot and continuous frame modes. It sits between the button debounce/reset logic and the output pin/buffer of the test-pattern top level.

Parameters:
WORD_WIDTH, 10, bits per frame word (frame length unit)
FRAME_WORDS, 8, words per frame; frame = FRAME_WORDS*WORD_WIDTH bits
POLY_LENGTH, 9, LFSR length (2..32)
POLY_TAP, 5, second feedback tap (1..POLY_LENGTH-1)
INV_PATTERN, 1, 1 = invert generated bit before output
SEED, all ones, LFSR load value (POLY_LENGTH bits, must be non-zero)
DIV_WIDTH, 4, width of speedctr
IDLE_LEVEL, 0, serial_out value when not transmitting
PREAMBLE, 10'b1111100000, WORD_WIDTH-bit preamble word (used only with PRBS_PREAMBLE_EN)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous reset, active-high
send_enable  input  1  one-cycle start pulse (debounced button)
continuous  input  1  1 = back-to-back frames until cleared
speedctr  input  DIV_WIDTH  bit period minus one, in clk cycles
serial_out  output  1  serial data, registered
bit_strobe  output  1  high for first clk of each bit period
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (rst=1 at clk edge): serial_out=IDLE_LEVEL, bit_strobe=0, busy=0, frame_done=0, LFSR=SEED, state IDLE. Reset mid-frame aborts immediately, with no frame_done.
- FSM: IDLE -> SHIFT on send_enable (PREAMBLE first if macro on); SHIFT -> IDLE after last bit if continuous=0; SHIFT -> SHIFT (next frame, no gap) if continuous=1.
- Start: send_enable sampled high in IDLE at cycle N:
  - LFSR reloaded to SEED.
  - speedctr latched into a shadow register; changes mid-frame are ignored until the next frame start.
  - First bit on serial_out at N+1; bit_strobe=1 and busy=1 at N+1.
- send_enable while busy: ignored.
- LFSR (Fibonacci): fb = s[POLY_LENGTH-1] ^ s[POLY_TAP-1]; s <= {s[POLY_LENGTH-2:0], fb}. Transmitted bit = fb ^ INV_PATTERN. Advances once per bit, at the bit's first cycle.
- Bit k (0-based) occupies cycles N+1+k*(P) .. N+k*P+P, where P = speedctr+1. speedctr=0 gives one bit per clk.
- Bit counter width is clog2 of total frame bits. It wraps to 0 at frame end.
- End of frame (cycle after last bit period):
  - frame_done=1 for one cycle.
  - continuous=0: serial_out=IDLE_LEVEL and busy=0 in the same cycle.
  - continuous=1: first bit of the next frame is driven in that same cycle (bit_strobe=1). LFSR is not reseeded, so the pattern runs on. speedctr is re-latched. busy stays 1.
- continuous cleared mid-frame: current frame completes, then IDLE.
- send_enable and frame end in the same cycle: send_enable ignored.

Optional Feature:
PRBS_PREAMBLE_EN:
- Defined: each frame (including continuous repeats) starts with PREAMBLE sent MSB first, at the same bit rate. The LFSR holds during the preamble. Frame length = (FRAME_WORDS+1)*WORD_WIDTH bits, and frame_done follows the last PRBS bit.
- Undefined: no preamble logic; PREAMBLE parameter unused.

Test Plan:
1. Defaults, speedctr=0, send_enable at cycle N -> serial_out bits 1,1,1,1,1,0,0,0,0 on cycles N+1..N+9; busy high N+1..N+80; frame_done at N+81; serial_out=0 at N+81.
2. speedctr=4, single frame -> each bit held 5 cycles; bit_strobe every 5th cycle (80 strobes total); frame_done at N+401.
3. continuous=1, speedctr=0, three frames -> frame_done at N+81, N+161, N+241; no idle gap; bit 81 continues the LFSR sequence, not SEED. Clear continuous during frame 3 -> busy=0 at N+241.
4. send_enable pulsed at N+10 during a frame, and speedctr changed 4->1 mid-frame -> no restart; bit period stays 5 until the frame ends.
5. rst=1 at cycle N+30 mid-frame -> next cycle serial_out=0, busy=0, no frame_done; a new send_enable replays 1,1,1,1,1,0,0,0,0.
6. PRBS_PREAMBLE_EN defined, speedctr=0 -> cycles N+1..N+10 carry 1111100000; PRBS 111110000 starts at N+11; frame_done at N+91.
